// File: rtl/mix_columns_engine_pkg.sv
// Shared AES column types and GF(2^8) helpers for the MixColumns engine.
// Optional inverse datapath is selected by macro MIX_COL_INV_EN.
package aes_mix_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] column_t;

    localparam byte_t AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; only instantiated with constant coefficients.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Block-level handshake and data bus of the MixColumns engine.
interface mix_columns_engine_if #(parameter int NB = 4);
    import aes_mix_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              inv_i;
    logic [32*NB-1:0]  state_i;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  state_o;

    modport slave (
        input  in_valid, inv_i, state_i, out_ready,
        output in_ready, out_valid, state_o
    );

    modport master (
        output in_valid, inv_i, state_i, out_ready,
        input  in_ready, out_valid, state_o
    );

endinterface

// File: rtl/mix_columns_engine_unit.sv
// Combinational single-column (Inv)MixColumns; inverse only when MIX_COL_INV_EN is defined.
module mix_column_unit
    import aes_mix_pkg::*;
(
    input  column_t col,
    input  logic    mode,
    output column_t res
);

`ifndef MIX_COL_INV_EN
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin : p_mix
        byte_t b0, b1, b2, b3, r;
        res = '0;
        b0  = '0;
        b1  = '0;
        b2  = '0;
        b3  = '0;
        r   = '0;
        for (int i = 0; i < 4; i++) begin
            b0 = col[31-8*i -: 8];
            b1 = col[31-8*((i+1)%4) -: 8];
            b2 = col[31-8*((i+2)%4) -: 8];
            b3 = col[31-8*((i+3)%4) -: 8];
            r  = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
`ifdef MIX_COL_INV_EN
            if (mode) begin
                r = gf_mul(8'h0E, b0) ^ gf_mul(8'h0B, b1) ^
                    gf_mul(8'h0D, b2) ^ gf_mul(8'h09, b3);
            end
`endif
            res[31-8*i -: 8] = r;
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: CPC columns per clock over an NB-column block.
// Define MIX_COL_INV_EN to build the InvMixColumns path and honour inv_i.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a block
// BUSY  | transforming CPC columns per cycle in the working register
// DONE  | out_valid=1, result held until out_ready
module mix_columns_engine
    import aes_mix_pkg::*;
#(
    parameter int NB  = 4,
    parameter int CPC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_columns_engine_if.slave  bus
);

    localparam int CW = $clog2(NB + 1);

    if (NB < 4 || NB > 8 || !(CPC == 1 || CPC == 2 || CPC == 4) || (NB % CPC) != 0) begin : g_bad_cfg
        $fatal(1, "mix_columns_engine: illegal NB=%0d CPC=%0d", NB, CPC);
    end

    mix_state_e        state_q;
    mix_state_e        state_d;
    logic [CW-1:0]     cnt_q;
    column_t           work_q [NB];
    logic              mode_q;
    column_t           unit_in  [CPC];
    column_t           unit_out [CPC];
    logic [32*NB-1:0]  state_flat;
    logic              accept;
    logic              last_step;

    assign accept    = (state_q == ST_IDLE) && bus.in_valid;
    assign last_step = (cnt_q == CW'(NB - CPC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_BUSY;
            ST_BUSY: if (last_step)     state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);

    // Counter stops at NB in DONE, so no column is ever revisited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= 1'b0;
            for (int c = 0; c < NB; c++) work_q[c] <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            mode_q <= bus.inv_i;
            for (int c = 0; c < NB; c++) work_q[c] <= bus.state_i[32*NB-1-32*c -: 32];
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CW'(CPC);
            for (int c = 0; c < NB; c++) begin
                for (int k = 0; k < CPC; k++) begin
                    if (int'(cnt_q) + k == c) work_q[c] <= unit_out[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CPC; k++) begin
            unit_in[k] = '0;
            for (int c = 0; c < NB; c++) begin
                if (int'(cnt_q) + k == c) unit_in[k] = work_q[c];
            end
        end
    end

    for (genvar k = 0; k < CPC; k++) begin : g_unit
        mix_column_unit u_col (
            .col  (unit_in[k]),
            .mode (mode_q),
            .res  (unit_out[k])
        );
    end

    always_comb begin
        state_flat = '0;
        for (int c = 0; c < NB; c++) state_flat[32*NB-1-32*c -: 32] = work_q[c];
    end

    assign bus.state_o = state_flat;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench: three engine configurations against a GF(2^8) matrix reference model.
module tb_mix_columns_engine;

`ifdef MIX_COL_INV_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mix_columns_engine_if #(.NB(4)) bus_a ();
    mix_columns_engine_if #(.NB(4)) bus_b ();
    mix_columns_engine_if #(.NB(8)) bus_c ();

    mix_columns_engine #(.NB(4), .CPC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mix_columns_engine #(.NB(4), .CPC(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    mix_columns_engine #(.NB(8), .CPC(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int           sel;
        bit           inv;
        logic [255:0] blk;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    // Reference: carry-less product reduced by 0x11B, then a 4x4 circulant matrix.
    function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_col(logic [31:0] c, bit inv);
        logic [7:0] coef [4];
        logic [7:0] b [4];
        logic [31:0] o;
        logic [7:0] acc;
        if (inv) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
        o = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(coef[j], b[(i+j)%4]);
            o[31-8*i -: 8] = acc;
        end
        return o;
    endfunction

    function automatic logic [255:0] ref_block(logic [255:0] blk, int nb, bit inv);
        logic [255:0] o;
        o = '0;
        for (int c = 0; c < nb; c++)
            o[32*nb-1-32*c -: 32] = ref_col(blk[32*nb-1-32*c -: 32], inv && INV_BUILT);
        return o;
    endfunction

    function automatic int nb_of(int sel);
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic int lat_of(int sel);
        case (sel)
            0:       return 4;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic get_valid(int sel);
        case (sel)
            0:       return bus_a.out_valid;
            1:       return bus_b.out_valid;
            default: return bus_c.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(int sel);
        case (sel)
            0:       return bus_a.in_ready;
            1:       return bus_b.in_ready;
            default: return bus_c.in_ready;
        endcase
    endfunction

    function automatic logic [255:0] get_out(int sel);
        case (sel)
            0:       return {128'h0, bus_a.state_o};
            1:       return {128'h0, bus_b.state_o};
            default: return bus_c.state_o;
        endcase
    endfunction

    task automatic set_in(int sel, logic v, logic inv, logic [255:0] blk);
        case (sel)
            0: begin bus_a.in_valid = v; bus_a.inv_i = inv; bus_a.state_i = blk[127:0]; end
            1: begin bus_b.in_valid = v; bus_b.inv_i = inv; bus_b.state_i = blk[127:0]; end
            default: begin bus_c.in_valid = v; bus_c.inv_i = inv; bus_c.state_i = blk; end
        endcase
    endtask

    task automatic set_ordy(int sel, logic r);
        case (sel)
            0:       bus_a.out_ready = r;
            1:       bus_b.out_ready = r;
            default: bus_c.out_ready = r;
        endcase
    endtask

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_blk(int nb, output logic [255:0] blk);
        blk = '0;
        for (int w = 0; w < nb; w++) blk[32*w +: 32] = $urandom;
    endtask

    // Offer a block, measure cycles from accept edge to out_valid, then complete the handshake.
    task automatic run_block(input int sel, input bit inv, input logic [255:0] blk,
                             output logic [255:0] res, output int lat);
        int n;
        @(negedge clk);
        set_in(sel, 1'b1, inv, blk);
        n = 0;
        while (!get_ready(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 1'b0, '0);
        lat = 0;
        while (!get_valid(sel) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = get_out(sel);
        @(negedge clk);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(sel, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] res, res2, blk, blk2, snap;
        int lat, sel, highs;
        bit inv;

        set_in(0, 1'b0, 1'b0, '0);
        set_in(1, 1'b0, 1'b0, '0);
        set_in(2, 1'b0, 1'b0, '0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        set_ordy(2, 1'b0);

        // Reset state
        #12;
        check("rst_out_valid", {253'h0, bus_a.out_valid, bus_b.out_valid, bus_c.out_valid}, 256'h0);
        check("rst_state_o", get_out(2) | get_out(0), 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {253'h0, bus_a.in_ready, bus_b.in_ready, bus_c.in_ready}, 256'h7);

        // Directed vectors
        vecs.push_back('{0, 1'b0, {128'h0, 32'hdb135345, 96'h0}, {128'h0, 32'h8e4da1bc, 96'h0}, 4});
        vecs.push_back('{1, 1'b0, {128'h0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5},
                                  {128'h0, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6}, 1});
        vecs.push_back('{0, 1'b0, {128'h0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5},
                                  {128'h0, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6}, 4});
        vecs.push_back('{2, 1'b0, {8{32'h2d26314c}}, {8{32'h4d7ebdf8}}, 4});
        vecs.push_back('{2, 1'b0, {128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 32'hdb135345, 96'h0},
                                  {128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, 32'h8e4da1bc, 96'h0}, 4});
`ifdef MIX_COL_INV_EN
        vecs.push_back('{0, 1'b1, {128'h0, 32'h8e4da1bc, 96'h0}, {128'h0, 32'hdb135345, 96'h0}, 4});
        vecs.push_back('{1, 1'b1, {128'h0, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6},
                                  {128'h0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5}, 1});
`else
        vecs.push_back('{0, 1'b1, {128'h0, 32'hdb135345, 96'h0}, {128'h0, 32'h8e4da1bc, 96'h0}, 4});
        vecs.push_back('{1, 1'b1, {128'h0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5},
                                  {128'h0, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6}, 1});
`endif
        foreach (vecs[i]) begin
            run_block(vecs[i].sel, vecs[i].inv, vecs[i].blk, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
        end

        // Random blocks against the reference model
        for (int t = 0; t < 30; t++) begin
            sel = int'($urandom_range(0, 2));
            inv = 1'($urandom_range(0, 1));
            rand_blk(nb_of(sel), blk);
            run_block(sel, inv, blk, res, lat);
            check($sformatf("rand%0d_data", t), res, ref_block(blk, nb_of(sel), inv));
            check($sformatf("rand%0d_latency", t), 256'(lat), 256'(lat_of(sel)));
        end

`ifdef MIX_COL_INV_EN
        for (int t = 0; t < 5; t++) begin
            rand_blk(8, blk);
            run_block(2, 1'b0, blk, res, lat);
            run_block(2, 1'b1, res, res2, lat);
            check($sformatf("roundtrip%0d", t), res2, blk);
        end
`endif

        // Mid-block input changes ignored, DONE held with backpressure
        blk  = {128'h0, 128'h00112233_44556677_8899aabb_ccddeeff};
        blk2 = {128'h0, 128'hdeadbeef_01234567_89abcdef_fedcba98};
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, blk);
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 1'b1, blk2);
        lat = 0;
        while (!get_valid(0) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_latency", 256'(lat), 256'd4);
        snap = ref_block(blk, 4, 1'b0);
        for (int h = 0; h < 10; h++) begin
            check($sformatf("hold%0d", h), {bus_a.out_valid, bus_a.in_ready, get_out(0)[127:0]},
                  {1'b1, 1'b0, snap[127:0]});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        set_ordy(0, 1'b1);
        @(posedge clk);
        #1;
        check("release_idle", {254'h0, bus_a.out_valid, bus_a.in_ready}, 256'h1);
        set_in(0, 1'b0, 1'b0, '0);
        set_ordy(0, 1'b0);
        highs = 0;
        for (int h = 0; h < 8; h++) begin
            @(posedge clk);
            #1;
            if (bus_a.out_valid) highs++;
        end
        check("no_block_after_release", 256'(highs), 256'd0);

        // Reset during BUSY cycle 2
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, blk2);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("busy_rst_async", {253'h0, bus_a.out_valid, bus_a.in_ready, |bus_a.state_o}, 256'h2);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int h = 0; h < 8; h++) begin
            @(posedge clk);
            #1;
            if (bus_a.out_valid) highs++;
        end
        check("busy_rst_no_output", 256'(highs), 256'd0);
        rand_blk(4, blk);
        run_block(0, 1'b0, blk, res, lat);
        check("after_rst_data", res, ref_block(blk, 4, 1'b0));
        check("after_rst_latency", 256'(lat), 256'd4);

        // Reset while holding a result in DONE
        @(negedge clk);
        set_in(2, 1'b1, 1'b0, blk2);
        @(posedge clk);
        #1;
        set_in(2, 1'b0, 1'b0, '0);
        lat = 0;
        while (!get_valid(2) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_rst_reached", {255'h0, bus_c.out_valid}, 256'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("done_rst_async", {254'h0, bus_c.out_valid, bus_c.in_ready}, 256'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rand_blk(8, blk);
        run_block(2, 1'b0, blk, res, lat);
        check("after_done_rst_data", res, ref_block(blk, 8, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter NB, default 4, number of 32-bit state columns (legal values 4..8; Rijndael block width).
REQ-002 SHALL have parameter CPC, default 1, columns processed per clock (legal values 1, 2, 4; must divide NB).
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all flops rise-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, input block valid.
REQ-006 SHALL have port in_ready, output, 1 bit, engine can accept a block.
REQ-007 SHALL have port inv_i, input, 1 bit, 0 = MixColumns, 1 = InvMixColumns; sampled with the block.
REQ-008 SHALL have port state_i, input, 32*NB bits; column c = state_i[32*NB-1-32c -: 32], byte 0 of each column in its MSB.
REQ-009 SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-011 SHALL have port state_o, output, 32*NB bits, result, same packing as state_i.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 IDLE: in_ready=1; in_valid&&in_ready captures state_i and inv_i, clears column counter, goes to BUSY.
REQ-014 BUSY: each cycle transforms CPC columns at counter index in place, counter += CPC; after the NB/CPC-th cycle goes to DONE.
REQ-015 Latency SHALL be exactly NB/CPC cycles from accept edge to out_valid rising (NB=4, CPC=1: 4 cycles; CPC=4: 1 cycle).
REQ-016 DONE: out_valid=1, state_o stable; holds indefinitely while out_ready=0.
REQ-017 DONE with out_ready=1: goes to IDLE next edge; no new block is accepted in that same cycle (in_ready=0 in BUSY and DONE).
REQ-018 Forward column math: a_i = 2*b_i ^ 3*b_(i+1) ^ b_(i+2) ^ b_(i+3), indices mod 4, GF(2^8) modulo 0x11B.
REQ-019 Inverse column math: coefficients 0E,0B,0D,09 in same rotation.
REQ-020 in_valid or inv_i changes during BUSY/DONE SHALL be ignored; latched mode applies to the whole block.
REQ-021 Counter SHALL not wrap past NB; no columns transformed twice.
REQ-022 state_o SHALL equal the working register; its value is undefined by contract while out_valid=0.

Reset
REQ-023 On rst_n low, asynchronously: FSM=IDLE, counter=0, out_valid=0, working register and latched mode=0; in_ready SHALL be 1 one edge after rst_n deasserts.
REQ-024 Reset mid-BUSY or mid-DONE SHALL discard the block with no partial output.

Configuration
REQ-025 Macro MIX_COL_INV_EN defined: inverse path built, inv_i honoured.
REQ-026 Macro MIX_COL_INV_EN undefined: inverse multipliers absent, inv_i ignored, forward-only; all other timing identical.

Structure
REQ-027 Package aes_mix_pkg SHALL hold byte_t, column_t typedefs, AES_POLY=8'h1B constant, and xtime/gf_mul functions.
REQ-028 One sub-module mix_column_unit (combinational, one column, mode input) SHALL be instantiated CPC times.
REQ-029 Illegal NB/CPC combinations SHALL stop elaboration with $fatal.

Verification
REQ-030 NB=4,CPC=1, forward, column db135345 (others 00) -> column 8e4da1bc, out_valid exactly 4 cycles after accept.
REQ-031 Forward columns f20a225c, 01010101, c6c6c6c6, d4d4d4d5 -> 9fdc589d, 01010101, c6c6c6c6, d5d5d7d6 in one block, CPC=4, latency 1.
REQ-032 MIX_COL_INV_EN, inv_i=1, column 8e4da1bc -> db135345; round-trip of random blocks returns input.
REQ-033 out_ready held 0 for 10 cycles in DONE -> state_o stable, in_ready=0, new in_valid ignored; release -> IDLE next edge.
REQ-034 rst_n pulsed low during BUSY cycle 2 -> out_valid=0 immediately, no output for that block, next block processed correctly.
REQ-035 NB=8,CPC=2, 2d26314c in all columns -> 4d7ebdf8 in all columns, latency 4.
